// File: rtl/masked_rca_sched.sv
// masked_rca_sched: round-robin scheduler that steps a masked ripple-carry adder one stage per cycle.
module masked_rca_sched #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    input  logic         req1_valid,
    output logic         req0_ready,
    output logic         req1_ready,
    input  logic [N-1:0] req0_a0,
    input  logic [N-1:0] req0_a1,
    input  logic [N-1:0] req0_b0,
    input  logic [N-1:0] req0_b1,
    input  logic [N-1:0] req1_a0,
    input  logic [N-1:0] req1_a1,
    input  logic [N-1:0] req1_b0,
    input  logic [N-1:0] req1_b1,
    output logic [N-1:0] dp_a0,
    output logic [N-1:0] dp_a1,
    output logic [N-1:0] dp_b0,
    output logic [N-1:0] dp_b1,
    output logic         dp_clr,
    output logic [N-1:0] dp_stage_en,
    input  logic [N-1:0] dp_s,
    input  logic         dp_cout,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic         resp_id,
    output logic [N:0]   resp_sum,
    output logic         busy,
    output logic [7:0]   ops_done
);
    localparam int KW = $clog2(N);
    typedef enum logic [2:0] {IDLE, LOAD, RUN, CAPT, DONE} state_t;
    state_t state, state_n;
    logic [KW-1:0] k;
    logic last_grant, grant, accept;
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end
    // On a tie the requester that did not win last time is granted.
    always_comb begin
        grant = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
        req0_ready = (state == IDLE) && !rst && !grant;
        req1_ready = (state == IDLE) && !rst && grant;
        accept = (req0_valid && req0_ready) || (req1_valid && req1_ready);
        busy = state != IDLE;
        resp_valid = state == DONE;
        dp_clr = state == LOAD;
        dp_stage_en = (state == RUN) ? (N'(1) << k) : '0;
        state_n = state;
        case (state)
            IDLE: state_n = accept ? LOAD : IDLE;
            LOAD: state_n = RUN;
            RUN: state_n = (k == KW'(N - 1)) ? CAPT : RUN;
            CAPT: state_n = DONE;
            DONE: state_n = resp_ready ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            k <= '0;
            last_grant <= 1'b1;
            dp_a0 <= '0;
            dp_a1 <= '0;
            dp_b0 <= '0;
            dp_b1 <= '0;
            resp_id <= 1'b0;
            resp_sum <= '0;
            ops_done <= '0;
        end else begin
            k <= (state == RUN) ? k + 1'b1 : '0;
            if (accept) begin
                last_grant <= grant;
                resp_id <= grant;
                dp_a0 <= grant ? req1_a0 : req0_a0;
                dp_a1 <= grant ? req1_a1 : req0_a1;
                dp_b0 <= grant ? req1_b0 : req0_b0;
                dp_b1 <= grant ? req1_b1 : req0_b1;
            end
            if (state == CAPT) resp_sum <= {dp_cout, dp_s};
            if (resp_valid && resp_ready) ops_done <= ops_done + 8'd1;
        end
    end
endmodule

// File: tb/tb_masked_rca_sched.sv
// tb_masked_rca_sched: random and directed transactions against an arithmetic reference and a bit-serial datapath.
module tb_masked_rca_sched;
    localparam int N = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req0_valid = 1'b0, req1_valid = 1'b0, resp_ready = 1'b0;
    logic [N-1:0] req0_a0 = '0, req0_a1 = '0, req0_b0 = '0, req0_b1 = '0;
    logic [N-1:0] req1_a0 = '0, req1_a1 = '0, req1_b0 = '0, req1_b1 = '0;
    logic req0_ready, req1_ready, dp_clr, resp_valid, resp_id, busy, dp_cout;
    logic [N-1:0] dp_a0, dp_a1, dp_b0, dp_b1, dp_stage_en, dp_s;
    logic [N:0] resp_sum;
    logic [7:0] ops_done;
    logic [N-1:0] s_r = '0, c_r = '0;
    logic [7:0] exp_ops = 8'd0;
    logic wrap_seen = 1'b0;
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    masked_rca_sched #(.N(N)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_a0(req0_a0), .req0_a1(req0_a1), .req0_b0(req0_b0), .req0_b1(req0_b1),
        .req1_a0(req1_a0), .req1_a1(req1_a1), .req1_b0(req1_b0), .req1_b1(req1_b1),
        .dp_a0(dp_a0), .dp_a1(dp_a1), .dp_b0(dp_b0), .dp_b1(dp_b1),
        .dp_clr(dp_clr), .dp_stage_en(dp_stage_en), .dp_s(dp_s), .dp_cout(dp_cout),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_sum(resp_sum), .busy(busy), .ops_done(ops_done)
    );

    // Stand-in datapath: each enabled stage adds its unmasked bits with the previous stage's carry.
    wire [N-1:0] av = dp_a0 ^ dp_a1;
    wire [N-1:0] bv = dp_b0 ^ dp_b1;
    wire [N-1:0] cin = {c_r[N-2:0], 1'b0};
    always @(posedge clk) begin
        if (dp_clr) begin
            s_r <= '0;
            c_r <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (dp_stage_en[i]) begin
                    s_r[i] <= av[i] ^ bv[i] ^ cin[i];
                    c_r[i] <= (av[i] & bv[i]) | (cin[i] & (av[i] ^ bv[i]));
                end
            end
        end
    end
    assign dp_s = s_r;
    assign dp_cout = c_r[N-1];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int id, input logic v, input logic [N-1:0] a0, a1, b0, b1);
        if (id == 0) begin
            req0_valid = v; req0_a0 = a0; req0_a1 = a1; req0_b0 = b0; req0_b1 = b1;
        end else begin
            req1_valid = v; req1_a0 = a0; req1_a1 = a1; req1_b0 = b0; req1_b1 = b1;
        end
    endtask

    task automatic txn(input int id, input logic [N-1:0] a0, a1, b0, b1, input int bp);
        logic [N:0] exp_sum;
        int w;
        exp_sum = (N+1)'(a0 ^ a1) + (N+1)'(b0 ^ b1);
        drive(id, 1'b1, a0, a1, b0, b1);
        resp_ready = (bp == 0);
        #1;
        w = 0;
        while (!(id != 0 ? req1_ready : req0_ready) && w < 40) begin
            @(negedge clk);
            #1;
            w++;
        end
        chk("accept", 32'(id != 0 ? req1_ready : req0_ready), 32'd1);
        @(negedge clk);
        drive(id, 1'b0, a0, a1, b0, b1);
        chk("load_clr", 32'(dp_clr), 32'd1);
        chk("load_busy", 32'(busy), 32'd1);
        chk("load_ops", 32'({dp_a0, dp_a1, dp_b0, dp_b1}), 32'({a0, a1, b0, b1}));
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            chk("run_en", 32'(dp_stage_en), 32'(1 << i));
            chk("run_clr", 32'(dp_clr), 32'd0);
            chk("run_valid", 32'(resp_valid), 32'd0);
        end
        @(negedge clk);
        chk("capt_en", 32'(dp_stage_en), 32'd0);
        chk("capt_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        chk("resp_valid", 32'(resp_valid), 32'd1);
        chk("resp_sum", 32'(resp_sum), 32'(exp_sum));
        chk("resp_id", 32'(resp_id), 32'(id));
        for (int i = 0; i < bp; i++) begin
            chk("bp_valid", 32'(resp_valid), 32'd1);
            chk("bp_sum", 32'(resp_sum), 32'(exp_sum));
            chk("bp_id", 32'(resp_id), 32'(id));
            chk("bp_ready", 32'({req0_ready, req1_ready}), 32'd0);
            chk("bp_busy", 32'(busy), 32'd1);
            chk("bp_ops", 32'(ops_done), 32'(exp_ops));
            if (i == bp - 1) resp_ready = 1'b1;
            @(negedge clk);
        end
        if (bp == 0) @(negedge clk);
        exp_ops = exp_ops + 8'd1;
        if (exp_ops == 8'd0) wrap_seen = 1'b1;
        chk("ops_done", 32'(ops_done), 32'(exp_ops));
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_valid", 32'(resp_valid), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
        drive(0, 1'b0, '0, '0, '0, '0);
        drive(1, 1'b0, '0, '0, '0, '0);
        rst = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(resp_valid), 32'd0);
        chk("rst_id_sum", 32'({resp_id, resp_sum}), 32'd0);
        chk("rst_ops", 32'(ops_done), 32'd0);
        chk("rst_dp", 32'({dp_a0, dp_a1, dp_b0, dp_b1, dp_stage_en, dp_clr}), 32'd0);

        txn(0, 4'b0101, 4'b0000, 4'b0011, 4'b0101, 0);
        chk("basic_sum", 32'(resp_sum), 32'b01011);
        txn(1, 4'b1010, 4'b0101, 4'b0001, 4'b0000, 0);
        chk("carry_sum", 32'(resp_sum), 32'b10000);

        // Ties right after reset: requester 0 first, then 1, then 0 again.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_ops = 8'd0;
        drive(0, 1'b1, 4'b0011, 4'b0001, 4'b0110, 4'b0010);
        drive(1, 1'b1, 4'b1111, 4'b0000, 4'b1000, 4'b0001);
        #1;
        chk("tie_first", 32'({req0_ready, req1_ready}), 32'b10);
        txn(0, 4'b0011, 4'b0001, 4'b0110, 4'b0010, 0);
        #1;
        chk("tie_second", 32'({req0_ready, req1_ready}), 32'b01);
        txn(1, 4'b1111, 4'b0000, 4'b1000, 4'b0001, 4);
        drive(0, 1'b1, 4'b1001, 4'b0110, 4'b0111, 4'b0111);
        drive(1, 1'b1, 4'b0001, 4'b0001, 4'b0001, 4'b0001);
        #1;
        chk("tie_third", 32'({req0_ready, req1_ready}), 32'b10);
        txn(0, 4'b1001, 4'b0110, 4'b0111, 4'b0111, 3);
        drive(1, 1'b0, '0, '0, '0, '0);

        // Reset while stage 2 is enabled: the request vanishes without a response.
        drive(0, 1'b1, 4'b0111, 4'b0000, 4'b0111, 4'b0000);
        resp_ready = 1'b1;
        #1;
        chk("mid_accept", 32'(req0_ready), 32'd1);
        @(negedge clk);
        drive(0, 1'b0, '0, '0, '0, '0);
        repeat (3) @(negedge clk);
        chk("mid_k2", 32'(dp_stage_en), 32'b0100);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_ops = 8'd0;
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_en", 32'(dp_stage_en), 32'd0);
        chk("mid_valid", 32'(resp_valid), 32'd0);
        chk("mid_ops", 32'(ops_done), 32'd0);
        @(negedge clk);
        chk("mid_noresp", 32'(resp_valid), 32'd0);
        txn(1, 4'b0110, 4'b1100, 4'b0011, 4'b1001, 0);

        for (int t = 0; t < 256; t++)
            txn(int'($urandom_range(1)), N'($urandom), N'($urandom), N'($urandom), N'($urandom), 0);
        chk("wrap_seen", 32'(wrap_seen), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/masked_rca_sched.md
# masked_rca_sched

Scheduler and arbiter for the single-clock, enable-stepped masked N-bit ripple-carry adder datapath. It accepts share-split add requests (a0/a1, b0/b1) from two requesters and arbitrates between them round-robin. It steps the datapath one bit-stage per cycle through a one-hot stage enable, captures the carry-out and sum, and returns the result with the requester ID. Shares pass through unchanged: the block never XORs a0 with a1 or b0 with b1.

## Interface
- N, default 4: operand width in bits, N >= 2.
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid, req1_valid  in  1  request from requester 0 or 1.
- req0_ready, req1_ready  out  1  request accepted when valid && ready on the same edge.
- req0_a0, req0_a1, req0_b0, req0_b1  in  N  requester 0 operand shares.
- req1_a0, req1_a1, req1_b0, req1_b1  in  N  requester 1 operand shares.
- dp_a0, dp_a1, dp_b0, dp_b1  out  N  registered shares driven to the datapath.
- dp_clr  out  1  one-cycle pulse that clears the datapath carry/stage registers.
- dp_stage_en  out  N  one-hot enable; bit k lets datapath stage k register on that edge.
- dp_s  in  N  datapath sum bits.
- dp_cout  in  1  datapath carry out of stage N-1.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts the result.
- resp_id  out  1  requester that issued the result.
- resp_sum  out  N+1  result, {dp_cout, dp_s}.
- busy  out  1  high in any state other than IDLE.
- ops_done  out  8  count of completed responses; wraps from 255 to 0.

## Operation
- States:
  - IDLE: wait for a request.
  - LOAD: latch granted operands into dp_*; dp_clr=1.
  - RUN: dp_stage_en = 1<<k for k=0..N-1; counter k is clog2(N) bits wide.
  - CAPT: sample {dp_cout, dp_s} into resp_sum.
  - DONE: hold resp_valid until resp_ready.
- Transitions:
  - IDLE→LOAD when a request is accepted.
  - LOAD→RUN with k=0.
  - RUN stays in RUN while k<N-1, incrementing k each cycle; on k=N-1, RUN→CAPT.
  - CAPT→DONE.
  - DONE→IDLE on resp_valid && resp_ready.
- Arbitration:
  - reqX_ready = (state==IDLE) && grant==X.
  - grant goes to the only valid requester if just one is valid.
  - If both are valid, grant goes to the requester other than last_grant.
  - last_grant updates on acceptance.
  - The ready outputs are combinational from state, the valids and last_grant. Both readies are never high together.
- The operand registers and resp_id load on the accept edge and stay stable until the next accept.
- ops_done increments on the resp handshake edge.
- Datapath contract: stage k updates its s and carry registers on an edge where dp_stage_en[k]=1, using the carry from stage k-1 (0 for k=0). dp_s and dp_cout are final during CAPT.
- Reset values:
  - state=IDLE, k=0, last_grant=1 (so requester 0 wins the first tie).
  - Both readies = 0 during the rst cycle.
  - dp_* = 0, dp_clr = 0, dp_stage_en = 0.
  - resp_valid = 0, resp_id = 0, resp_sum = 0, busy = 0, ops_done = 0.
- rst asserted in any state, including mid-RUN: return to IDLE next edge with reset values. The in-flight request is dropped and no response is issued.
- A request whose valid deasserts before acceptance is not recorded.
- Requests are not accepted while busy; requesters must hold valid and their operands until ready.

## Timing
- The accept edge ends cycle T. Cycle T+1 is LOAD.
- Cycles T+2 … T+N+1 are RUN, with k=0…N-1.
- Cycle T+N+2 is CAPT.
- resp_valid is first high in cycle T+N+3 (N+3 cycles after accept; 7 for N=4).
- The earliest next accept is the cycle after the resp handshake, giving a minimum issue interval of N+4 cycles.
- resp_sum and resp_id are stable while resp_valid=1 and resp_ready=0.
- dp_stage_en is 0 outside RUN. dp_clr is high only in LOAD.

## Test plan
- **Basic add** (N=4): req0 with a0=0101, a1=0000, b0=0011, b1=0101 (a=5, b=6). Require resp_valid 7 cycles after accept, resp_sum=01011, resp_id=0, ops_done=1.
- **Carry out**: req1 with a=15 (a0=1010, a1=0101) and b=1 (b0=0001, b1=0000). Require resp_sum=10000, resp_id=1; dp_stage_en steps 0001, 0010, 0100, 1000 on consecutive cycles.
- **Simultaneous requests** after reset: req0 is served first. req1 is accepted in the cycle after the first resp handshake, and its response has resp_id=1. With both valid again, req0 wins.
- **Backpressure**: hold resp_ready=0 for 3 cycles. Require resp_valid=1 and resp_sum/resp_id unchanged, both readies 0, busy=1, and ops_done incrementing only on the handshake.
- **Reset mid-RUN**: assert rst at k=2. Next cycle: state IDLE, dp_stage_en=0, resp_valid=0, busy=0, ops_done=0. A following request completes normally.
- **Counter wrap**: 256 back-to-back transactions with resp_ready tied to 1. Require ops_done to go from 255 to 0 and every result to equal a+b, where a = a0^a1 and b = b0^b1, for random shares.
